// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router control path.
// Holds the state encoding (3-bit binary), the reserved address code,
// the port count, and a helper that picks a per-port flag using a
// destination address. The synchronizer and the register stage import
// this package too, so every block sees the same encoding.
package router_fsm_pkg;

    localparam int          ADDR_W       = 2;
    localparam int          NUM_PORTS    = 3;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

    // Select one per-port flag by address. The reserved code selects no
    // port and returns 0.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags,
                                      input logic [ADDR_W-1:0]    addr);
        logic r;
        r = 1'b0;
        case (addr)
            2'd0:    r = flags[0];
            2'd1:    r = flags[1];
            2'd2:    r = flags[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router.
// Decodes the destination address from the header byte, sequences the
// header / payload / parity loads, and stalls the source with busy while
// the addressed FIFO is still occupied or full.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   pkt_valid, din            source handshake and header address field
//   fifo_full                 full flag of the addressed FIFO
//   fifo_empty_0..2           per-FIFO empty flags
//   soft_reset_0..2           per-FIFO read-timeout resets
//   parity_done               register stage captured the parity byte
//   low_pkt_valid             pkt_valid dropped while the FIFO was full
//   detect_addr .. busy       Moore outputs decoded from the state register
module router_fsm
    import router_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] din,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_addr,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              wr_en_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [NUM_PORTS-1:0] fifo_empty, soft_reset;

    assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        // A timeout on the port we are serving abandons the packet; a
        // timeout on any other port is none of our business.
        if (state_q != DECODE_ADDRESS && port_sel(soft_reset, addr_q)) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    // Headers carrying the reserved code are dropped.
                    if (pkt_valid && din != ADDR_INVALID) begin
                        addr_d  = din;
                        state_d = port_sel(fifo_empty, din) ? LOAD_FIRST_DATA
                                                            : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (port_sel(fifo_empty, addr_q))
                        state_d = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // Outputs depend on the state register only.
    assign detect_addr = (state_q == DECODE_ADDRESS);
    assign lfd_state   = (state_q == LOAD_FIRST_DATA);
    assign ld_state    = (state_q == LOAD_DATA);
    assign full_state  = (state_q == FIFO_FULL_STATE);
    assign laf_state   = (state_q == LOAD_AFTER_FULL);
    assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);
    assign wr_en_reg   = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == LOAD_AFTER_FULL);
    assign busy        = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [1:0] din;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_addr, lfd_state, ld_state, full_state, laf_state;
    logic       wr_en_reg, rst_int_reg, busy;

    int tests = 0;
    int fails = 0;

    // Expected output vectors {detect_addr,lfd,ld,full,laf,wr_en,rst_int,busy}
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_FUL = 8'b0001_0001;
    localparam logic [7:0] O_LAF = 8'b0000_1101;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_CPE = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .wr_en_reg(wr_en_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {detect_addr, lfd_state, ld_state, full_state,
               laf_state, wr_en_reg, rst_int_reg, busy};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pkt_valid = 0; din = 2'd0; fifo_full = 0;
        fifo_empty_0 = 0; fifo_empty_1 = 0; fifo_empty_2 = 0;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_pkt_valid = 0;
        tick(); tick();
        chk("reset_state", O_DA);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", O_DA);

        // Normal packet to port 1, four payload cycles.
        pkt_valid = 1; din = 2'd1; fifo_empty_1 = 1;
        tick(); chk("norm_lfd", O_LFD);
        din = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick(); chk($sformatf("norm_ld%0d", i), O_LD);
        end
        pkt_valid = 0;
        tick(); chk("norm_parity", O_LP);
        tick(); chk("norm_check", O_CPE);
        tick(); chk("norm_done", O_DA);

        // Busy target: port 2 not empty for 5 cycles.
        pkt_valid = 1; din = 2'd2; fifo_empty_2 = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); chk($sformatf("wait%0d", i), O_WTE);
        end
        fifo_empty_2 = 1;
        tick(); chk("wait_lfd", O_LFD);
        tick(); chk("wait_ld", O_LD);

        // Full in LOAD_DATA, then LAF with low_pkt_valid -> LOAD_PARITY.
        fifo_full = 1;
        tick(); chk("full0", O_FUL);
        tick(); chk("full1", O_FUL);
        fifo_full = 0;
        tick(); chk("laf", O_LAF);
        low_pkt_valid = 1;
        tick(); chk("laf_to_lp", O_LP);
        low_pkt_valid = 0; pkt_valid = 0;
        // Full during parity check goes back to waiting on the FIFO.
        fifo_full = 1;
        tick(); chk("lp_to_cpe", O_CPE);
        tick(); chk("cpe_full", O_FUL);
        fifo_full = 0;
        tick(); chk("cpe_laf", O_LAF);
        parity_done = 1;
        tick(); chk("laf_parity_done", O_DA);
        parity_done = 0;

        // LAF with neither flag returns to LOAD_DATA; full beats !pkt_valid.
        pkt_valid = 1; din = 2'd2;
        tick(); chk("p2_lfd", O_LFD);
        tick(); chk("p2_ld", O_LD);
        fifo_full = 1;
        tick(); chk("p2_full", O_FUL);
        fifo_full = 0;
        tick(); chk("p2_laf", O_LAF);
        tick(); chk("p2_laf_to_ld", O_LD);
        fifo_full = 1; pkt_valid = 0;
        tick(); chk("full_wins", O_FUL);
        fifo_full = 0; parity_done = 1;
        tick(); chk("p2_laf2", O_LAF);
        tick(); chk("p2_done", O_DA);
        parity_done = 0;

        // Soft reset: only the addressed port's timeout aborts.
        pkt_valid = 1; din = 2'd0; fifo_empty_0 = 1;
        tick(); chk("sr_lfd", O_LFD);
        tick(); chk("sr_ld", O_LD);
        soft_reset_1 = 1;
        tick(); chk("sr_other_ignored", O_LD);
        soft_reset_1 = 0; soft_reset_0 = 1;
        tick(); chk("sr_own_abort", O_DA);
        soft_reset_0 = 0; pkt_valid = 0;
        tick(); chk("sr_idle", O_DA);

        // Invalid address is dropped.
        pkt_valid = 1; din = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick(); chk($sformatf("inv%0d", i), O_DA);
        end
        pkt_valid = 0;

        // Reset mid-LOAD_DATA.
        pkt_valid = 1; din = 2'd1;
        tick(); chk("rst_lfd", O_LFD);
        tick(); chk("rst_ld", O_LD);
        rst = 1;
        tick(); chk("rst_mid0", O_DA);
        tick(); chk("rst_mid1", O_DA);
        rst = 0; pkt_valid = 0;
        tick(); chk("rst_after", O_DA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
